// File: rtl/fc_pkg.sv
// Shared types and helpers for the parametrised fully-connected engine:
// address-width helper, FSM states, pipeline tag and sign extension.
package fc_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Tag index is carried at a fixed generous width; engines slice what they need.
  localparam int TAG_IDX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic                 first;
    logic                 last;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  function automatic int aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sign-extend the low w bits of v to 64 bits.
  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = v;
    for (int i = 0; i < 64; i++) begin
      if (i >= w) r[i] = v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_engine_param_if.sv
// Bus bundle between the FC engine and its RAMs, multiplier array,
// control and output stream. master = engine side, slave = environment side.
interface fc_engine_param_if
  import fc_pkg::*;
#(
  parameter int LANES      = 128,
  parameter int DW         = 8,
  parameter int NUM_CHUNKS = 4,
  parameter int NUM_OUT    = 128,
  parameter int ACC_W      = 32
) ();
  localparam int IN_AW = aw(NUM_CHUNKS);
  localparam int W_AW  = aw(NUM_OUT * NUM_CHUNKS);
  localparam int IDX_W = aw(NUM_OUT);

  logic                  start_i;
  logic                  busy_o;
  logic                  done_o;
  logic [IN_AW-1:0]      in_addr_o;
  logic [LANES*DW-1:0]   in_data_i;
  logic [W_AW-1:0]       w_addr_o;
  logic [LANES*DW-1:0]   w_data_i;
  logic [IDX_W-1:0]      b_addr_o;
  logic [DW-1:0]         b_data_i;
  logic [LANES*DW-1:0]   mul_a_o;
  logic [LANES*DW-1:0]   mul_b_o;
  logic [LANES*2*DW-1:0] mul_p_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [ACC_W-1:0]      out_data_o;
  logic [IDX_W-1:0]      out_addr_o;

  modport master (
    input  start_i, in_data_i, w_data_i, b_data_i, mul_p_i, out_ready_i,
    output busy_o, done_o, in_addr_o, w_addr_o, b_addr_o, mul_a_o, mul_b_o,
           out_valid_o, out_data_o, out_addr_o
  );

  modport slave (
    output start_i, in_data_i, w_data_i, b_data_i, mul_p_i, out_ready_i,
    input  busy_o, done_o, in_addr_o, w_addr_o, b_addr_o, mul_a_o, mul_b_o,
           out_valid_o, out_data_o, out_addr_o
  );
endinterface

// File: rtl/fc_out_fifo.sv
// Small synchronous result FIFO; show-ahead head, zero when empty, and the
// occupancy count is exported so the engine can budget credits.
module fc_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_pop;

  assign empty_o    = (count_reg == '0);
  assign count_o    = count_reg;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = empty_o ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr_reg] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_i) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_i, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/fc_engine_param.sv
// Fully-connected layer sequencer: address issue FSM, tag pipe, lane reduction,
// accumulation and credit-guarded output FIFO. Define FC_RELU_EN to clamp results at 0.
module fc_engine_param
  import fc_pkg::*;
#(
  parameter int LANES      = 128,
  parameter int DW         = 8,
  parameter int NUM_CHUNKS = 4,
  parameter int NUM_OUT    = 128,
  parameter int RD_LAT     = 3,
  parameter int MUL_LAT    = 2,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk_i,
  input logic               rst_n_i,
  fc_engine_param_if.master bus
);
  localparam int IN_AW = aw(NUM_CHUNKS);
  localparam int W_AW  = aw(NUM_OUT * NUM_CHUNKS);
  localparam int IDX_W = aw(NUM_OUT);
  localparam int S     = RD_LAT + MUL_LAT + 1;   // stage where products are valid
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t               state_reg;
  logic [IDX_W-1:0]     nxt_out_reg;
  logic [IN_AW-1:0]     nxt_chunk_reg;
  logic [CNT_W-1:0]     inflight_reg;
  logic                 busy_reg, done_reg;
  logic [IN_AW-1:0]     in_addr_reg;
  logic [W_AW-1:0]      w_addr_reg;
  logic [IDX_W-1:0]     b_addr_reg;
  logic [LANES*DW-1:0]  mul_a_reg, mul_b_reg;
  logic [ACC_W-1:0]     acc_reg;
  tag_t                 tag_pipe [0:S];
  logic [DW-1:0]        bias_pipe [RD_LAT+1:S];

  tag_t                 tag_in, tail;
  logic                 new_neuron, last_chunk, last_out, credit_ok, fire, pipe_busy, push;
  logic [ACC_W-1:0]     sum_comb, acc_next, result;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  logic [ACC_W+IDX_W-1:0] fifo_head;

  assign new_neuron = (nxt_chunk_reg == '0);
  assign last_chunk = (nxt_chunk_reg == IN_AW'(NUM_CHUNKS - 1));
  assign last_out   = (nxt_out_reg == IDX_W'(NUM_OUT - 1));
  // A neuron may only start when its result is guaranteed a FIFO slot.
  assign credit_ok  = (int'(inflight_reg) + int'(fifo_count)) < FIFO_DEPTH;
  assign fire       = (state_reg == ISSUE) && (!new_neuron || credit_ok);
  assign tail       = tag_pipe[S];
  assign push       = tail.valid && tail.last;

  always_comb begin
    tag_in = '0;
    if (fire) begin
      tag_in.valid = 1'b1;
      tag_in.first = new_neuron;
      tag_in.last  = last_chunk;
      tag_in.idx   = TAG_IDX_W'(nxt_out_reg);
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k <= S; k++) pipe_busy = pipe_busy | tag_pipe[k].valid;
  end

  always_comb begin
    sum_comb = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_comb = sum_comb + ACC_W'(sext(64'(bus.mul_p_i[i*2*DW +: 2*DW]), 2*DW));
    end
    acc_next = (tail.first ? ACC_W'(sext(64'(bias_pipe[S]), DW)) : acc_reg) + sum_comb;
`ifdef FC_RELU_EN
    result = acc_next[ACC_W-1] ? '0 : acc_next;
`else
    result = acc_next;
`endif
  end

  generate
    for (genvar gi = 0; gi <= S; gi++) begin : g_tag
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     tag_pipe[gi] <= '0;
        else if (gi == 0) tag_pipe[gi] <= tag_in;
        else              tag_pipe[gi] <= tag_pipe[(gi == 0) ? 0 : gi-1];
      end
    end
    // Bias rides alongside its neuron's first tag so back-to-back neurons never collide.
    for (genvar gi = RD_LAT + 1; gi <= S; gi++) begin : g_bias
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          bias_pipe[gi] <= '0;
        end else if (gi == RD_LAT + 1) begin
          if (tag_pipe[RD_LAT].valid && tag_pipe[RD_LAT].first) bias_pipe[gi] <= bus.b_data_i;
        end else begin
          bias_pipe[gi] <= bias_pipe[(gi == RD_LAT + 1) ? gi : gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= IDLE;
      nxt_out_reg   <= '0;
      nxt_chunk_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      in_addr_reg   <= '0;
      w_addr_reg    <= '0;
      b_addr_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (bus.start_i) begin
          state_reg     <= ISSUE;
          busy_reg      <= 1'b1;
          nxt_out_reg   <= '0;
          nxt_chunk_reg <= '0;
        end
        ISSUE: if (fire) begin
          in_addr_reg <= nxt_chunk_reg;
          w_addr_reg  <= W_AW'(int'(nxt_out_reg) * NUM_CHUNKS + int'(nxt_chunk_reg));
          b_addr_reg  <= nxt_out_reg;
          if (last_chunk) begin
            nxt_chunk_reg <= '0;
            if (last_out) state_reg <= DRAIN;
            else          nxt_out_reg <= nxt_out_reg + 1'b1;
          end else begin
            nxt_chunk_reg <= nxt_chunk_reg + 1'b1;
          end
        end
        DRAIN: if (!pipe_busy && inflight_reg == '0 && fifo_empty) begin
          state_reg <= DONE;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mul_a_reg    <= '0;
      mul_b_reg    <= '0;
      acc_reg      <= '0;
      inflight_reg <= '0;
    end else begin
      if (tag_pipe[RD_LAT].valid) begin
        mul_a_reg <= bus.in_data_i;
        mul_b_reg <= bus.w_data_i;
      end
      if (tail.valid) acc_reg <= acc_next;
      case ({fire && new_neuron, push})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  fc_out_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ACC_W + IDX_W)) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (push),
    .push_data_i ({result, tail.idx[IDX_W-1:0]}),
    .pop_i       (bus.out_ready_i),
    .pop_data_o  (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign bus.busy_o      = busy_reg;
  assign bus.done_o      = done_reg;
  assign bus.in_addr_o   = in_addr_reg;
  assign bus.w_addr_o    = w_addr_reg;
  assign bus.b_addr_o    = b_addr_reg;
  assign bus.mul_a_o     = mul_a_reg;
  assign bus.mul_b_o     = mul_b_reg;
  assign bus.out_valid_o = !fifo_empty;
  assign bus.out_data_o  = fifo_head[ACC_W+IDX_W-1:IDX_W];
  assign bus.out_addr_o  = fifo_head[IDX_W-1:0];
endmodule

// File: tb/tb_fc_engine_param.sv
// Directed bench for fc_engine_param with behavioural RAM and multiplier models.
module tb_fc_engine_param;
  localparam int LANES = 4, DW = 8, NUM_CHUNKS = 2, NUM_OUT = 3;
  localparam int RD_LAT = 1, MUL_LAT = 1, ACC_W = 32, FIFO_DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // mode 0: every lane/address returns in_val/w_val/b_val; mode 1: address-dependent data
  int               mode = 0;
  logic signed [7:0] in_val = 0, w_val = 0, b_val = 0;

  always #5 clk = ~clk;

  fc_engine_param_if #(.LANES(LANES), .DW(DW), .NUM_CHUNKS(NUM_CHUNKS),
                       .NUM_OUT(NUM_OUT), .ACC_W(ACC_W)) bus ();

  fc_engine_param #(.LANES(LANES), .DW(DW), .NUM_CHUNKS(NUM_CHUNKS), .NUM_OUT(NUM_OUT),
                    .RD_LAT(RD_LAT), .MUL_LAT(MUL_LAT), .ACC_W(ACC_W),
                    .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // One-cycle RAMs and one-cycle multiplier array.
  always @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      logic signed [7:0] a8, b8;
      bus.in_data_i[l*DW +: DW] <= (mode == 0) ? in_val : 8'(int'(bus.in_addr_o) + 1);
      bus.w_data_i[l*DW +: DW]  <= (mode == 0) ? w_val  : 8'(int'(bus.w_addr_o) + 1);
      a8 = bus.mul_a_o[l*DW +: DW];
      b8 = bus.mul_b_o[l*DW +: DW];
      bus.mul_p_i[l*2*DW +: 2*DW] <= 16'(int'(a8) * int'(b8));
    end
    bus.b_data_i <= (mode == 0) ? b_val : 8'(int'(bus.b_addr_o) * 10);
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_job(input string name, input int stall, input bit mid_start,
                         input int e0, input int e1, input int e2);
    int exp_v [3];
    int n_out, done_cnt, done_cyc;
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2;
    n_out = 0; done_cnt = 0; done_cyc = 0;
    bus.out_ready_i = (stall == 0);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (stall > 0 && cyc == stall) bus.out_ready_i = 1'b1;
      if (mid_start) bus.start_i = (cyc == 3);
      if (cyc == 0) check({name, ".busy_after_start"}, bus.busy_o, 1);
      if (stall > 0 && cyc == stall - 1) begin
        check({name, ".stall_valid"}, bus.out_valid_o, 1);
        check({name, ".stall_head_addr"}, bus.out_addr_o, 0);
        check({name, ".stall_w_addr_hold"}, bus.w_addr_o, 3);
        check({name, ".stall_no_done"}, done_cnt, 0);
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (n_out < 3) begin
          check({name, ".addr"}, bus.out_addr_o, n_out);
          check({name, ".data"}, $signed(bus.out_data_o), exp_v[n_out]);
        end
        n_out++;
      end
      if (bus.done_o) begin
        if (done_cnt == 0) check({name, ".busy_drops_with_done"}, bus.busy_o, 0);
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && cyc >= done_cyc + 5) break;
    end
    bus.start_i = 1'b0;
    check({name, ".outputs"}, n_out, 3);
    check({name, ".done_pulses"}, done_cnt, 1);
    check({name, ".idle_busy"}, bus.busy_o, 0);
    $display("[TB] %s: %0d outputs, %0d done pulses", name, n_out, done_cnt);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.busy", bus.busy_o, 0);
    check("reset.done", bus.done_o, 0);
    check("reset.valid", bus.out_valid_o, 0);
    check("reset.w_addr", bus.w_addr_o, 0);
    check("reset.out_data", bus.out_data_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    in_val = 1; w_val = 2; b_val = 5;
    run_job("t1_basic", 0, 0, 21, 21, 21);

    in_val = -1; w_val = 127; b_val = -3;
`ifdef FC_RELU_EN
    run_job("t2_negative", 0, 0, 0, 0, 0);
`else
    run_job("t2_negative", 0, 0, -1019, -1019, -1019);
`endif

    in_val = -128; w_val = -128; b_val = 127;
    run_job("t3_extreme", 0, 0, 131199, 131199, 131199);

    in_val = 1; w_val = 2; b_val = 5;
    run_job("t4_backpressure", 30, 0, 21, 21, 21);
    run_job("t5_start_while_busy", 0, 1, 21, 21, 21);
    run_job("t5_repeat", 0, 0, 21, 21, 21);

    mode = 1;
    run_job("t7_addr_dependent", 0, 0, 20, 54, 88);

    // Reset in the middle of ISSUE, then restart.
    bus.out_ready_i = 1'b1;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("t6.pre_reset_busy", bus.busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("t6.busy", bus.busy_o, 0);
    check("t6.valid", bus.out_valid_o, 0);
    check("t6.w_addr", bus.w_addr_o, 0);
    check("t6.b_addr", bus.b_addr_o, 0);
    check("t6.mul_a", bus.mul_a_o, 0);
    check("t6.out_data", bus.out_data_o, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 4) check("t6.no_done", bus.done_o, 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t6.idle_after_reset", bus.done_o, 0);
    run_job("t6_restart", 0, 0, 20, 54, 88);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
